// File: rtl/sobel_gradient_if.sv
// sobel_gradient_if
//   Pixel-stream and result bundle for sobel_gradient.
//   Handshake: a pixel moves on a rising clk edge where pixel_valid and
//   pixel_ready are both high. pixel_in and full_load are meaningful only
//   while pixel_valid is high. The producer may raise or drop pixel_valid
//   freely. pixel_ready never depends on pixel_valid.
//   Signals:
//     pixel_valid  producer -> block  pixel_in holds a pixel
//     pixel_in     producer -> block  8-bit unsigned grayscale pixel
//     full_load    producer -> block  first pixel of burst: 1 = 9-pixel load, 0 = column shift
//     pixel_ready  block -> producer  block accepts a pixel this cycle
//     gx, gy       block -> consumer  10-bit two's-complement gradients (halved)
//     calc_done    block -> consumer  one-cycle pulse: gx/gy just updated
interface sobel_gradient_if;
    logic       pixel_valid;
    logic [7:0] pixel_in;
    logic       full_load;
    logic       pixel_ready;
    logic [9:0] gx;
    logic [9:0] gy;
    logic       calc_done;

    modport master (
        output pixel_valid, pixel_in, full_load,
        input  pixel_ready, gx, gy, calc_done
    );

    modport slave (
        input  pixel_valid, pixel_in, full_load,
        output pixel_ready, gx, gy, calc_done
    );
endinterface

// File: rtl/sobel_gradient.sv
// sobel_gradient
//   Collects a 3x3 window of 8-bit pixels, either as a full row-major load
//   of 9 pixels or as a 3-pixel column shift. It then computes the Sobel
//   gradients over two pipeline cycles: partial sums, then difference and halving.
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous active-high reset
//     pix_if   sobel_gradient_if.slave (pixel handshake in, gx/gy/calc_done out)
//     state_o  current FSM state (0 IDLE, 1 LOAD, 2 CALC1, 3 CALC2), for observation
module sobel_gradient (
    input  logic                   clk,
    input  logic                   rst,
    sobel_gradient_if.slave        pix_if,
    output logic [1:0]             state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CALC1 = 2'd2,
        CALC2 = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        full_q, full_d;
    logic [7:0]  win_q [9];
    logic [7:0]  win_d [9];
    logic [7:0]  col_q [2];
    logic [7:0]  col_d [2];
    logic [9:0]  gxp_q, gxp_d, gxn_q, gxn_d;
    logic [9:0]  gyp_q, gyp_d, gyn_q, gyn_d;
    logic [9:0]  gx_q, gx_d, gy_q, gy_d;
    logic        done_q, done_d;
    logic        accept;
    logic [10:0] gx_full, gy_full;

    // a + 2b + c, at most 1020, so it fits in 10 bits unsigned
    function automatic logic [9:0] tap_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // Ready is forced low during reset so nothing is accepted while the block is held
    assign pix_if.pixel_ready = !rst && ((state_q == IDLE) || (state_q == LOAD));
    assign accept             = pix_if.pixel_valid && pix_if.pixel_ready;

    // Window index is r*3 + c
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        full_d  = full_q;
        win_d   = win_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    full_d  = pix_if.full_load;
                    count_d = 4'd1;
                    if (pix_if.full_load) win_d[0] = pix_if.pixel_in;
                    else                  col_d[0] = pix_if.pixel_in;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    count_d = count_q + 4'd1;
                    if (full_q) begin
                        win_d[count_q] = pix_if.pixel_in;
                        if (count_q == 4'd8) begin
                            count_d = 4'd0;
                            state_d = CALC1;
                        end
                    end else if (count_q == 4'd2) begin
                        // Third pixel of a column: shift left and append the new column
                        for (int r = 0; r < 3; r++) begin
                            win_d[r*3]     = win_q[r*3 + 1];
                            win_d[r*3 + 1] = win_q[r*3 + 2];
                        end
                        win_d[2] = col_q[0];
                        win_d[5] = col_q[1];
                        win_d[8] = pix_if.pixel_in;
                        count_d  = 4'd0;
                        state_d  = CALC1;
                    end else begin
                        col_d[1] = pix_if.pixel_in;
                    end
                end
            end
            CALC1:   state_d = CALC2;
            CALC2:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Arithmetic pipeline: stage 1 registers the four positive/negative tap sums,
    // stage 2 subtracts at 11 bits and drops the LSB (arithmetic shift, floor).
    assign gx_full = {1'b0, gxp_q} - {1'b0, gxn_q};
    assign gy_full = {1'b0, gyp_q} - {1'b0, gyn_q};

    always_comb begin
        gxp_d  = gxp_q;
        gxn_d  = gxn_q;
        gyp_d  = gyp_q;
        gyn_d  = gyn_q;
        gx_d   = gx_q;
        gy_d   = gy_q;
        done_d = 1'b0;
        if (state_q == CALC1) begin
            gxp_d = tap_sum(win_q[2], win_q[5], win_q[8]);
            gxn_d = tap_sum(win_q[0], win_q[3], win_q[6]);
            gyp_d = tap_sum(win_q[6], win_q[7], win_q[8]);
            gyn_d = tap_sum(win_q[0], win_q[1], win_q[2]);
        end
        if (state_q == CALC2) begin
            gx_d   = gx_full[10:1];
            gy_d   = gy_full[10:1];
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            full_q  <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= 8'd0;
            for (int i = 0; i < 2; i++) col_q[i] <= 8'd0;
            gxp_q   <= 10'd0;
            gxn_q   <= 10'd0;
            gyp_q   <= 10'd0;
            gyn_q   <= 10'd0;
            gx_q    <= 10'd0;
            gy_q    <= 10'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= full_d;
            win_q   <= win_d;
            col_q   <= col_d;
            gxp_q   <= gxp_d;
            gxn_q   <= gxn_d;
            gyp_q   <= gyp_d;
            gyn_q   <= gyn_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            done_q  <= done_d;
        end
    end

    assign pix_if.gx        = gx_q;
    assign pix_if.gy        = gy_q;
    assign pix_if.calc_done = done_q;
    assign state_o          = state_q;

endmodule

// File: doc/sobel_gradient.md
# sobel_gradient

Computes the signed horizontal and vertical Sobel gradients (gx, gy) of a 3x3 window of 8-bit grayscale pixels. It sits directly upstream of the magnitude block in the edge-detection datapath. Pixels arrive serially through a valid/ready handshake, either as a full 9-pixel window load or as a 3-pixel column shift. Results are registered and announced with a one-cycle calc_done pulse that the magnitude block consumes.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  system clock; rising-edge active.
- rst  input  1  reset; asynchronous, active-high.
- pixel_valid  input  1  pixel_in holds a pixel this cycle.
- pixel_in  input  8  unsigned grayscale pixel.
- full_load  input  1  sampled only on the first accepted pixel of a burst: 1 = 9-pixel window load, 0 = 3-pixel column shift.
- pixel_ready  output  1  block accepts a pixel this cycle.
- gx  output  10  signed horizontal gradient, two's complement.
- gy  output  10  signed vertical gradient, two's complement.
- calc_done  output  1  one-cycle pulse: gx/gy updated.

## Operation
- Window w[r][c], r = row 0..2 (top..bottom), c = column 0..2 (left..right).
- A pixel is accepted on a rising edge where pixel_valid && pixel_ready.
- Full load: pixels arrive row-major, w00,w01,w02,w10,…,w22. Each pixel is written into its window slot as it is accepted.
- Column shift: pixels arrive top, middle, bottom. They are buffered. On the edge that accepts the third pixel, column 0 takes column 1, column 1 takes column 2, and column 2 takes the buffered column, all on that same edge.
- A column shift with no prior full load operates on the zeroed window contents.
- FSM states:
  - IDLE: pixel_ready=1. On acceptance, latch the burst length (9 or 3) from full_load and the count. Go to LOAD, or straight to CALC1 if the burst length is 1 (it never is).
  - LOAD: pixel_ready=1. On the final pixel of the burst, go to CALC1.
  - CALC1: pixel_ready=0. Register the partial sums. Go to CALC2.
  - CALC2: pixel_ready=0. Register gx, gy. Assert calc_done on the same edge. Go to IDLE.
- pixel_valid during CALC1/CALC2 is ignored. Nothing is buffered or counted.
- Arithmetic, at 11-bit signed internally:
  - Gx = (w02 + 2·w12 + w22) − (w00 + 2·w10 + w20)
  - Gy = (w20 + 2·w21 + w22) − (w00 + 2·w01 + w02)
  - Range is ±1020.
- Output scaling: gx = Gx >>> 1 and gy = Gy >>> 1. This is an arithmetic shift that rounds toward −∞, so the output range is ±510. The output therefore never overflows 10 bits.
- gx/gy hold their values until the next CALC2 edge.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE; window, column buffer and pixel counter all cleared to 0.
  - gx=0, gy=0, calc_done=0.
  - pixel_ready=0 while rst is high, and 1 in the first cycle after release.
- Latency: if the last burst pixel is accepted at edge N:
  - partial sums are registered at N+1;
  - gx/gy update and calc_done rises at N+2;
  - calc_done falls at N+3.
- calc_done is high for exactly one cycle per completed burst.
- pixel_ready is high again in the cycle after edge N+2, the same cycle calc_done is high. A new burst may start in that cycle.
- Back-to-back full loads give a throughput of 11 cycles per window. Back-to-back column shifts take 5 cycles per result.
- Gaps in pixel_valid during LOAD stall the burst indefinitely. The count is preserved and there is no timeout.
- full_load is ignored after the first pixel of a burst.
- rst asserted mid-burst or mid-calc aborts everything: the partial burst is discarded, no calc_done is issued, and gx/gy clear to 0.

## Test plan
- Reset: assert rst for 2 cycles, then release. Required: gx=0, gy=0, calc_done=0, and pixel_ready=1 in the cycle after release.
- Uniform window: full load with all nine pixels = 64. Required: gx=0, gy=0, and calc_done high exactly one cycle, 2 edges after the 9th pixel is accepted; pixel_ready=0 during CALC1/CALC2.
- Left-bright edge, then column shift:
  - Full load with column 0 = 255 and columns 1 and 2 = 0. Required: gx = −510 (10'b1000000010) and gy = 0.
  - Then a column shift with (255,255,255), giving columns 0,0,255. Required: gx = +510 and gy = 0.
- Horizontal edge and rounding:
  - Full load with the top row = 255, rest 0. Required: gy = −510, gx = 0.
  - Full load with only w00 = 1. Required: gx = gy = 10'h3FF (−1, round toward −∞).
- Stall, ignore and abort:
  - Hold pixel_valid=1 throughout CALC1/CALC2. Required: no extra pixels counted and the next burst starts cleanly.
  - Deassert pixel_valid for 4 cycles mid-burst. Required: result identical to an unstalled burst.
  - Assert rst after 5 pixels. Required: no calc_done, outputs 0, and the next full load produces the correct result.
